// File: rtl/wc_tile_sequencer_if.sv
// Handshake and core-facing bus bundle for wc_tile_sequencer.
// slave = the sequencer, master = its environment (sample source/sink, frame control, WC core).
interface wc_tile_sequencer_if #(
   parameter int DW    = 10,
   parameter int WIN   = 6,
   parameter int OUTN  = 2,
   parameter int LEN_W = 12
) ();
   logic                 start;
   logic [LEN_W-1:0]     frame_len;
   logic                 busy;
   logic                 done;
   logic                 err;
   logic                 in_valid;
   logic [DW-1:0]        in_data;
   logic                 in_ready;
   logic [WIN*DW-1:0]    wc_d;
   logic [OUTN*DW-1:0]   wc_z;
   logic                 out_valid;
   logic [OUTN*DW-1:0]   out_data;
   logic                 out_last;
   logic                 out_ready;

   modport slave (
      input  start, frame_len, in_valid, in_data, wc_z, out_ready,
      output busy, done, err, in_ready, wc_d, out_valid, out_data, out_last
   );

   modport master (
      output start, frame_len, in_valid, in_data, wc_z, out_ready,
      input  busy, done, err, in_ready, wc_d, out_valid, out_data, out_last
   );
endinterface

// File: rtl/wc_tile_sequencer.sv
// Frame sequencer for the Winograd core: stride-2 sliding window, fixed-latency launch tracking,
// credit-guarded result FIFO. Define WC_SEQ_PAD_EN for same-size (zero-padded) frames.
module wc_tile_sequencer #(
   parameter int DW         = 10,
   parameter int WIN        = 6,
   parameter int OUTN       = 2,
   parameter int WC_LAT     = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_W      = 12
) (
   input logic                clk,
   input logic                rst,
   wc_tile_sequencer_if.slave bus
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + WC_LAT + 1);
   localparam int KW = $clog2(WIN + 1);
`ifdef WC_SEQ_PAD_EN
   localparam int               FILL_N  = WIN - 2;
   localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(2);
`else
   localparam int               FILL_N  = WIN;
   localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(WIN);
`endif

   typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;
   typedef struct packed {
      logic                last;
      logic [OUTN*DW-1:0]  data;
   } tile_t;

   state_t              state, state_n;
   logic [LEN_W-1:0]    remaining;
   logic [KW-1:0]       cnt, cnt_n;
   logic [WIN*DW-1:0]   win_q;
   logic [WC_LAT:1]     vld_pipe, lst_pipe;
   tile_t               mem [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [CW-1:0]       fifo_count, inflight;
   logic                legal, credit, rdy, accept, inject, final_feed, launch;
   logic                push, pop, drain_ok, done_q, err_q;
`ifdef WC_SEQ_PAD_EN
   logic [1:0]          pad_left;
`endif

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   always_comb begin
      inflight = '0;
      for (int i = 1; i <= WC_LAT; i++) inflight = inflight + CW'(vld_pipe[i]);
   end

   // Tiles in flight already own a FIFO slot, so the FIFO can never overflow.
   assign credit   = (fifo_count + inflight) < CW'(FIFO_DEPTH);
   assign legal    = !bus.frame_len[0] && (bus.frame_len >= MIN_LEN);
   assign push     = vld_pipe[WC_LAT];
   assign pop      = bus.out_valid && bus.out_ready;
   assign drain_ok = (inflight == '0) && (fifo_count == '0);

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      rdy        = 1'b0;
      accept     = 1'b0;
      inject     = 1'b0;
      final_feed = 1'b0;
      launch     = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (bus.start && legal) state_n = FILL;
         end
         FILL, RUN: begin
            rdy    = (remaining != '0) && credit;
            accept = rdy && bus.in_valid;
`ifdef WC_SEQ_PAD_EN
            inject     = (remaining == '0) && (pad_left != '0) && credit;
            final_feed = inject && (pad_left == 2'd1);
`else
            final_feed = accept && (remaining == LEN_W'(1));
`endif
            if (accept || inject) begin
               if (state == FILL) begin
                  launch = (cnt == KW'(FILL_N - 1));
                  cnt_n  = launch ? '0 : cnt + KW'(1);
               end else begin
                  launch = cnt[0];
                  cnt_n  = launch ? '0 : KW'(1);
               end
               if (final_feed)  state_n = DRAIN;
               else if (launch) state_n = RUN;
            end
         end
         DRAIN: if (drain_ok) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         remaining <= '0;
         cnt       <= '0;
         win_q     <= '0;
         vld_pipe  <= '0;
         lst_pipe  <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
`ifdef WC_SEQ_PAD_EN
         pad_left  <= '0;
`endif
      end else begin
         done_q <= (state == DRAIN) && drain_ok;
         err_q  <= (state == IDLE) && bus.start && !legal;
         cnt    <= cnt_n;
         if (state == IDLE && bus.start && legal) begin
            remaining <= bus.frame_len;
`ifdef WC_SEQ_PAD_EN
            pad_left  <= 2'd2;
            win_q     <= '0;
`endif
         end
         if (accept) remaining <= remaining - LEN_W'(1);
`ifdef WC_SEQ_PAD_EN
         if (inject) pad_left <= pad_left - 2'd1;
`endif
         // Oldest sample leaves slot 0, the new one (or a pad zero) enters slot WIN-1.
         if (accept || inject)
            win_q <= {(accept ? bus.in_data : {DW{1'b0}}), win_q[WIN*DW-1:DW]};
         vld_pipe[1] <= launch;
         lst_pipe[1] <= launch && final_feed;
         for (int i = 2; i <= WC_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            lst_pipe[i] <= lst_pipe[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{last: lst_pipe[WC_LAT], data: bus.wc_z};
   end

   // Read side is gated so an empty or freshly reset FIFO presents zeros.
   assign bus.out_valid = (fifo_count != '0);
   assign bus.out_data  = bus.out_valid ? mem[rd_ptr].data : '0;
   assign bus.out_last  = bus.out_valid && mem[rd_ptr].last;
   assign bus.in_ready  = rdy;
   assign bus.wc_d      = win_q;
   assign bus.busy      = (state != IDLE);
   assign bus.done      = done_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_wc_tile_sequencer.sv
// Directed bench for wc_tile_sequencer with a one-register WC core model (sum of window halves).
module tb_wc_tile_sequencer;
   localparam int DW = 10, WIN = 6, OUTN = 2, WC_LAT = 2, FIFO_DEPTH = 4, LEN_W = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   sent;
   logic [20:0] q [$];
   logic [WIN*DW-1:0] exp_wd;

   localparam logic [20:0] T20 [8] = '{
      {1'b0, 10'd15, 10'd6},  {1'b0, 10'd21, 10'd12}, {1'b0, 10'd27, 10'd18}, {1'b0, 10'd33, 10'd24},
      {1'b0, 10'd39, 10'd30}, {1'b0, 10'd45, 10'd36}, {1'b0, 10'd51, 10'd42}, {1'b1, 10'd57, 10'd48}};

   wc_tile_sequencer_if #(.DW(DW), .WIN(WIN), .OUTN(OUTN), .LEN_W(LEN_W)) bus ();

   wc_tile_sequencer #(.DW(DW), .WIN(WIN), .OUTN(OUTN), .WC_LAT(WC_LAT),
                       .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // WC core: WC_LAT=2 means one register between wc_d and wc_z.
   always @(posedge clk)
      bus.wc_z <= {bus.wc_d[3*DW +: DW] + bus.wc_d[4*DW +: DW] + bus.wc_d[5*DW +: DW],
                   bus.wc_d[0 +: DW] + bus.wc_d[DW +: DW] + bus.wc_d[2*DW +: DW]};

   always @(negedge clk)
      if (!rst && bus.out_valid && bus.out_ready) q.push_back({bus.out_last, bus.out_data});

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_pulse(input int len);
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.frame_len = LEN_W'(len);
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic feed(input int first, input int n, input int budget, output int cnt);
      logic acc;
      cnt = 0;
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(first);
      for (int c = 0; c < budget && cnt < n; c++) begin
         @(negedge clk);
         acc = bus.in_valid && bus.in_ready;
         @(posedge clk); #1;
         if (acc) cnt++;
         bus.in_data = DW'(first + cnt);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      logic seen = 1'b0;
      for (int c = 0; c < budget && !seen; c++) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
      end
      chk({tag, "_done"}, 64'(seen), 64'd1);
      chk({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
   endtask

   task automatic chk_idle_outs(input string tag);
      chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
      chk({tag, "_done"}, 64'(bus.done), 64'd0);
      chk({tag, "_err"}, 64'(bus.err), 64'd0);
      chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
      chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
      chk({tag, "_out_last"}, 64'(bus.out_last), 64'd0);
      chk({tag, "_out_data"}, 64'(bus.out_data), 64'd0);
      chk({tag, "_wc_d"}, 64'(bus.wc_d), 64'd0);
   endtask

   initial begin
      bus.start = 1'b0; bus.frame_len = '0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk_idle_outs("reset");
      @(posedge clk); #1 rst = 1'b0;

      // Rejected starts
`ifdef WC_SEQ_PAD_EN
      for (int k = 0; k < 2; k++) begin
         start_pulse(k == 0 ? 7 : 0);
`else
      for (int k = 0; k < 2; k++) begin
         start_pulse(k == 0 ? 7 : 4);
`endif
         @(negedge clk);
         chk("err_pulse", 64'(bus.err), 64'd1);
         chk("err_busy", 64'(bus.busy), 64'd0);
         chk("err_in_ready", 64'(bus.in_ready), 64'd0);
         @(negedge clk);
         chk("err_clear", 64'(bus.err), 64'd0);
         chk("err_busy2", 64'(bus.busy), 64'd0);
      end

`ifdef WC_SEQ_PAD_EN
      // Padded frame: windows {0,0,1,2,3,4} and {1,2,3,4,0,0}
      q.delete();
      start_pulse(4);
      feed(1, 4, 20, sent);
      chk("pad_sent", 64'(sent), 64'd4);
      wait_done("pad", 40);
      chk("pad_ntiles", 64'(q.size()), 64'd2);
      chk("pad_tile0", 64'((q.size() > 0) ? q[0] : 21'bx), 64'({1'b0, 10'd9, 10'd1}));
      chk("pad_tile1", 64'((q.size() > 1) ? q[1] : 21'bx), 64'({1'b1, 10'd4, 10'd6}));
`else
      // Single-tile frame
      q.delete();
      start_pulse(6);
      @(negedge clk);
      chk("f6_busy", 64'(bus.busy), 64'd1);
      chk("f6_in_ready", 64'(bus.in_ready), 64'd1);
      feed(1, 6, 20, sent);
      for (int k = 0; k < WIN; k++) exp_wd[k*DW +: DW] = DW'(k + 1);
      @(negedge clk);
      chk("f6_wc_d", 64'(bus.wc_d), 64'(exp_wd));
      wait_done("f6", 40);
      chk("f6_ntiles", 64'(q.size()), 64'd1);
      chk("f6_tile", 64'((q.size() > 0) ? q[0] : 21'bx), 64'({1'b1, 10'd15, 10'd6}));

      // Three tiles, last only on the third
      q.delete();
      start_pulse(10);
      feed(1, 10, 30, sent);
      wait_done("f10", 40);
      chk("f10_ntiles", 64'(q.size()), 64'd3);
      chk("f10_tile0", 64'((q.size() > 0) ? q[0] : 21'bx), 64'({1'b0, 10'd15, 10'd6}));
      chk("f10_tile1", 64'((q.size() > 1) ? q[1] : 21'bx), 64'({1'b0, 10'd21, 10'd12}));
      chk("f10_tile2", 64'((q.size() > 2) ? q[2] : 21'bx), 64'({1'b1, 10'd27, 10'd18}));

      // Back-pressure: credit stops input after 4 tiles are owed
      q.delete();
      bus.out_ready = 1'b0;
      start_pulse(20);
      feed(1, 20, 30, sent);
      chk("bp_sent", 64'(sent), 64'd12);
      @(negedge clk);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_out_data", 64'({bus.out_last, bus.out_data}), 64'(T20[0]));
      bus.out_ready = 1'b1;
      feed(13, 8, 60, sent);
      chk("bp_sent2", 64'(sent), 64'd8);
      wait_done("bp", 40);
      chk("bp_ntiles", 64'(q.size()), 64'd8);
      for (int i = 0; i < 8; i++)
         chk($sformatf("bp_tile%0d", i), 64'((i < q.size()) ? q[i] : 21'bx), 64'(T20[i]));

      // Reset mid-frame with buffered results, then a clean frame
      bus.out_ready = 1'b0;
      start_pulse(20);
      feed(1, 8, 20, sent);
      chk("rst_sent", 64'(sent), 64'd8);
      repeat (4) @(negedge clk);
      chk("rst_pre_valid", 64'(bus.out_valid), 64'd1);
      #2 rst = 1'b1;
      #1 chk_idle_outs("rst_mid");
      @(posedge clk); #1 rst = 1'b0;
      q.delete();
      bus.out_ready = 1'b1;
      start_pulse(6);
      feed(1, 6, 20, sent);
      wait_done("rst_f6", 40);
      chk("rst_f6_ntiles", 64'(q.size()), 64'd1);
      chk("rst_f6_tile", 64'((q.size() > 0) ? q[0] : 21'bx), 64'({1'b1, 10'd15, 10'd6}));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
